// File: rtl/axi4_rw_arbiter_if.sv
// Bundle for the two-requester front end and the single-beat AXI4 master port.
// The master modport is the arbiter's view; slave is the environment's view.
interface axi4_rw_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [31:0] req_wdata0;
  logic [31:0] req_wdata1;
  logic [3:0]  req_wstrb0;
  logic [3:0]  req_wstrb1;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        arlen;
  logic        arsize;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        awlen;
  logic        awsize;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
           req_wstrb0, req_wstrb1,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output arvalid, araddr, arlen, arsize, input arready,
    input  rvalid, rdata, rresp, output rready,
    output awvalid, awaddr, awlen, awsize, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready
  );

  modport slave (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
           req_wstrb0, req_wstrb1,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  arvalid, araddr, arlen, arsize, output arready,
    output rvalid, rdata, rresp, input rready,
    input  awvalid, awaddr, awlen, awsize, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready
  );
endinterface

// File: rtl/axi4_rw_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one AXI4 master port between two
// single-beat requesters; one transaction outstanding, one tagged response pulse each.
module axi4_rw_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic                      i_aclk,
  input  logic                      i_areset,
  axi4_rw_arbiter_if.master         bus
);

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP} state_t;

  state_t      r_state, w_next;
  logic        r_last;
  logic        r_id;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done, r_w_done;
  logic        r_rsp_valid, r_rsp_id, r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_grant, w_accept;
  logic [1:0]  w_req_ready;
  logic        w_awvalid, w_wvalid, w_aw_hs, w_w_hs;

  // Tie goes to whoever was not served last unless fixed priority is selected
  always_comb begin
    w_grant = 1'b0;
    case (bus.req_valid)
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
      default: w_grant = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && (|bus.req_valid);

  always_comb begin
    w_req_ready = 2'b00;
    if (r_state == S_IDLE) w_req_ready[w_grant] = bus.req_valid[w_grant];
  end

  assign w_awvalid = (r_state == S_WREQ) && !r_aw_done;
  assign w_wvalid  = (r_state == S_WREQ) && !r_w_done;
  assign w_aw_hs   = w_awvalid && bus.awready;
  assign w_w_hs    = w_wvalid && bus.wready;

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = bus.req_write[w_grant] ? S_WREQ : S_RADDR;
      S_RADDR: if (bus.arready) w_next = S_RDATA;
      S_RDATA: if (bus.rvalid) w_next = S_IDLE;
      S_WREQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WRESP;
      S_WRESP: if (bus.bvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_id      <= w_grant;
        r_last    <= w_grant;
        r_addr    <= w_grant ? bus.req_addr1  : bus.req_addr0;
        r_wdata   <= w_grant ? bus.req_wdata1 : bus.req_wdata0;
        r_wstrb   <= w_grant ? bus.req_wstrb1 : bus.req_wstrb0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (r_state == S_RDATA && bus.rvalid) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_rdata <= bus.rdata;
        r_rsp_err   <= (bus.rresp != 2'b00);
      end
      if (r_state == S_WRESP && bus.bvalid) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_rdata <= '0;
        r_rsp_err   <= (bus.bresp != 2'b00);
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  assign bus.arvalid = (r_state == S_RADDR);
  assign bus.araddr  = r_addr;
  assign bus.arlen   = 1'b0;
  assign bus.arsize  = 1'b0;
  assign bus.rready  = (r_state == S_RDATA);
  assign bus.awvalid = w_awvalid;
  assign bus.awaddr  = r_addr;
  assign bus.awlen   = 1'b0;
  assign bus.awsize  = 1'b0;
  assign bus.wvalid  = w_wvalid;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = r_wstrb;
  assign bus.bready  = (r_state == S_WRESP);

endmodule

// File: tb/tb_axi4_rw_arbiter.sv
// Directed bench: transaction-level model checked every cycle on the round-robin
// instance, plus literal expectations and a fixed-priority instance.
module tb_axi4_rw_arbiter;
  logic clk, rst, rst2;
  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  bit done2 = 0;
  logic grant_q[$];
  logic fp_ids[$];

  axi4_rw_arbiter_if bus ();
  axi4_rw_arbiter_if bus2 ();

  axi4_rw_arbiter #(.FIXED_PRIO(0)) dut  (.i_aclk(clk), .i_areset(rst),  .bus(bus.master));
  axi4_rw_arbiter #(.FIXED_PRIO(1)) dut2 (.i_aclk(clk), .i_areset(rst2), .bus(bus2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transaction-level model of the round-robin instance
  logic        m_busy, m_wr, m_id, m_last;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ar_done, m_aw_done, m_w_done;
  logic        m_due, m_rid, m_rerr;
  logic [31:0] m_rdata;

  function automatic logic model_grant(input logic [1:0] v, input logic last);
    if (v == 2'b10) return 1'b1;
    if (v == 2'b11) return ~last;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_wr = 0; m_id = 0; m_last = 1; m_addr = 0; m_wdata = 0; m_wstrb = 0;
    m_ar_done = 0; m_aw_done = 0; m_w_done = 0; m_due = 0; m_rid = 0; m_rerr = 0; m_rdata = 0;
  endtask

  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic g, due;
    if (rst) m_reset();
    g = model_grant(bus.req_valid, m_last);
    exp_ready = 2'b00;
    if (!m_busy && (|bus.req_valid)) exp_ready[g] = 1'b1;
    if (!rst) chk("m_req_ready", {30'd0, bus.req_ready}, {30'd0, exp_ready});
    chk("m_arvalid", {31'd0, bus.arvalid}, {31'd0, m_busy && !m_wr && !m_ar_done});
    chk("m_rready",  {31'd0, bus.rready},  {31'd0, m_busy && !m_wr && m_ar_done});
    chk("m_awvalid", {31'd0, bus.awvalid}, {31'd0, m_busy && m_wr && !m_aw_done});
    chk("m_wvalid",  {31'd0, bus.wvalid},  {31'd0, m_busy && m_wr && !m_w_done});
    chk("m_bready",  {31'd0, bus.bready},  {31'd0, m_busy && m_wr && m_aw_done && m_w_done});
    chk("m_rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_due});
    chk("m_len_size", {28'd0, bus.arlen, bus.arsize, bus.awlen, bus.awsize}, 32'd0);
    if (m_busy && !m_wr && !m_ar_done) chk("m_araddr", bus.araddr, m_addr);
    if (m_busy && m_wr && !m_aw_done) chk("m_awaddr", bus.awaddr, m_addr);
    if (m_busy && m_wr && !m_w_done) begin
      chk("m_wdata", bus.wdata, m_wdata);
      chk("m_wstrb", {28'd0, bus.wstrb}, {28'd0, m_wstrb});
    end
    if (m_due) begin
      chk("m_rsp_id", {31'd0, bus.rsp_id}, {31'd0, m_rid});
      chk("m_rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("m_rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_rerr});
    end
    if (bus.rsp_valid) rsp_cnt++;
    if (!rst && (bus.req_ready & bus.req_valid) != 2'b00) grant_q.push_back(bus.req_ready[1]);

    if (!rst) begin
      due = 0;
      if (!m_busy) begin
        if (|bus.req_valid) begin
          m_busy = 1; m_id = g; m_last = g; m_wr = bus.req_write[g];
          m_addr  = g ? bus.req_addr1  : bus.req_addr0;
          m_wdata = g ? bus.req_wdata1 : bus.req_wdata0;
          m_wstrb = g ? bus.req_wstrb1 : bus.req_wstrb0;
          m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
        end
      end else if (!m_wr) begin
        if (!m_ar_done) begin
          if (bus.arready) m_ar_done = 1;
        end else if (bus.rvalid) begin
          due = 1; m_rid = m_id; m_rdata = bus.rdata; m_rerr = (bus.rresp != 0); m_busy = 0;
        end
      end else begin
        if (m_aw_done && m_w_done) begin
          if (bus.bvalid) begin
            due = 1; m_rid = m_id; m_rdata = 0; m_rerr = (bus.bresp != 0); m_busy = 0;
          end
        end else begin
          if (bus.awready) m_aw_done = 1;
          if (bus.wready)  m_w_done = 1;
        end
      end
      m_due = due;
    end
  end

  // Fixed-priority instance: both requesters always valid, zero-wait slave
  initial begin
    rst2 = 1'b1;
    bus2.req_valid = 2'b00; bus2.req_write = 2'b00;
    bus2.req_addr0 = 32'h100; bus2.req_addr1 = 32'h200;
    bus2.req_wdata0 = 0; bus2.req_wdata1 = 0; bus2.req_wstrb0 = 0; bus2.req_wstrb1 = 0;
    bus2.arready = 1; bus2.rvalid = 1; bus2.rdata = 32'h55; bus2.rresp = 0;
    bus2.awready = 1; bus2.wready = 1; bus2.bvalid = 1; bus2.bresp = 0;
    tick(2);
    rst2 = 1'b0;
    bus2.req_valid = 2'b11;
    for (int i = 0; i < 60 && fp_ids.size() < 4; i++) begin
      @(negedge clk);
      if (bus2.rsp_valid) fp_ids.push_back(bus2.rsp_id);
    end
    bus2.req_valid = 2'b00;
    done2 = 1;
  end

  initial begin
    int base;
    rst = 1'b1;
    bus.req_valid = 0; bus.req_write = 0;
    bus.req_addr0 = 0; bus.req_addr1 = 0; bus.req_wdata0 = 0; bus.req_wdata1 = 0;
    bus.req_wstrb0 = 0; bus.req_wstrb1 = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    tick(2);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_araddr", bus.araddr, 32'd0);
    rst = 1'b0;

    // Single read on requester 0
    tick(1);
    bus.req_valid = 2'b01; bus.req_write = 2'b00; bus.req_addr0 = 32'h1000; bus.arready = 1;
    #1 chk("t1_req_ready", {30'd0, bus.req_ready}, 32'd1);
    tick(1);
    bus.req_valid = 0;
    chk("t1_arvalid", {31'd0, bus.arvalid}, 32'd1);
    chk("t1_araddr", bus.araddr, 32'h1000);
    tick(1);
    chk("t1_rready", {31'd0, bus.rready}, 32'd1);
    bus.rvalid = 1; bus.rdata = 32'hDEADBEEF; bus.rresp = 0;
    tick(1);
    bus.rvalid = 0; bus.arready = 0;
    chk("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t1_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("t1_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("t1_rsp_err", {31'd0, bus.rsp_err}, 32'd0);

    // Round-robin with both requesters continuously valid, after a fresh reset
    tick(1);
    rst = 1; tick(1); rst = 0;
    grant_q.delete();
    bus.req_valid = 2'b11; bus.req_write = 2'b00;
    bus.req_addr0 = 32'h100; bus.req_addr1 = 32'h200;
    bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'h11112222; bus.rresp = 0;
    for (int i = 0; i < 40 && grant_q.size() < 4; i++) tick(1);
    bus.req_valid = 0;
    tick(4);
    bus.arready = 0; bus.rvalid = 0;
    chk("t2_grant_count", {31'd0, grant_q.size() >= 4}, 32'd1);
    if (grant_q.size() >= 4) begin
      chk("t2_grant0", {31'd0, grant_q[0]}, 32'd0);
      chk("t2_grant1", {31'd0, grant_q[1]}, 32'd1);
      chk("t2_grant2", {31'd0, grant_q[2]}, 32'd0);
      chk("t2_grant3", {31'd0, grant_q[3]}, 32'd1);
    end

    // Skewed write from requester 1 with SLVERR
    tick(1);
    bus.req_valid = 2'b10; bus.req_write = 2'b10; bus.req_addr1 = 32'h20;
    bus.req_wdata1 = 32'h12345678; bus.req_wstrb1 = 4'hF;
    tick(1);
    bus.req_valid = 0;
    chk("t3_awvalid_t1", {31'd0, bus.awvalid}, 32'd1);
    chk("t3_wvalid_t1", {31'd0, bus.wvalid}, 32'd1);
    bus.wready = 1;
    tick(1);
    bus.wready = 0;
    chk("t3_wvalid_dropped", {31'd0, bus.wvalid}, 32'd0);
    chk("t3_awvalid_held", {31'd0, bus.awvalid}, 32'd1);
    chk("t3_bready_early", {31'd0, bus.bready}, 32'd0);
    tick(1);
    chk("t3_awaddr", bus.awaddr, 32'h20);
    bus.awready = 1;
    tick(1);
    bus.awready = 0;
    chk("t3_awvalid_dropped", {31'd0, bus.awvalid}, 32'd0);
    chk("t3_bready", {31'd0, bus.bready}, 32'd1);
    bus.bvalid = 1; bus.bresp = 2'd2;
    tick(1);
    bus.bvalid = 0; bus.bresp = 0;
    chk("t3_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t3_rsp_id", {31'd0, bus.rsp_id}, 32'd1);
    chk("t3_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    chk("t3_rsp_rdata", bus.rsp_rdata, 32'd0);

    // Slow read slave with requester 1 waiting throughout
    tick(1);
    bus.req_valid = 2'b01; bus.req_write = 2'b00; bus.req_addr0 = 32'h3000;
    tick(1);
    base = rsp_cnt;
    bus.req_valid = 2'b10; bus.req_addr1 = 32'h4000;
    tick(3);
    chk("t4_araddr_held", bus.araddr, 32'h3000);
    chk("t4_ready_busy", {30'd0, bus.req_ready}, 32'd0);
    bus.arready = 1;
    tick(1);
    bus.arready = 0;
    chk("t4_rready", {31'd0, bus.rready}, 32'd1);
    tick(2);
    bus.rvalid = 1; bus.rdata = 32'hCAFEF00D; bus.rresp = 0; bus.req_valid = 0;
    tick(1);
    bus.rvalid = 0;
    chk("t4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t4_rsp_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    tick(3);
    chk("t4_single_pulse", rsp_cnt - base, 32'd1);

    // DECERR on a read from requester 1
    bus.req_valid = 2'b10; bus.req_write = 2'b00; bus.req_addr1 = 32'h5000; bus.arready = 1;
    tick(1);
    bus.req_valid = 0;
    tick(1);
    bus.rvalid = 1; bus.rdata = 32'h0BADF00D; bus.rresp = 2'd3;
    tick(1);
    bus.rvalid = 0; bus.rresp = 0; bus.arready = 0;
    chk("t5_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t5_rsp_id", {31'd0, bus.rsp_id}, 32'd1);
    chk("t5_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    chk("t5_rsp_rdata", bus.rsp_rdata, 32'h0BADF00D);

    // Reset in the middle of a write, then a tie that requester 0 must win
    tick(1);
    bus.req_valid = 2'b01; bus.req_write = 2'b01; bus.req_addr0 = 32'h40;
    bus.req_wdata0 = 32'hAA; bus.req_wstrb0 = 4'h3;
    tick(1);
    bus.req_valid = 0;
    chk("t6_awvalid_before", {31'd0, bus.awvalid}, 32'd1);
    tick(1);
    rst = 1;
    #1;
    chk("t6_awvalid_reset", {31'd0, bus.awvalid}, 32'd0);
    chk("t6_wvalid_reset", {31'd0, bus.wvalid}, 32'd0);
    chk("t6_rsp_valid_reset", {31'd0, bus.rsp_valid}, 32'd0);
    tick(1);
    rst = 0;
    tick(1);
    bus.req_valid = 2'b11; bus.req_write = 2'b00;
    bus.req_addr0 = 32'h50; bus.req_addr1 = 32'h60; bus.arready = 1;
    #1 chk("t6_tie_ready", {30'd0, bus.req_ready}, 32'd1);
    tick(1);
    bus.req_valid = 0;
    chk("t6_araddr", bus.araddr, 32'h50);
    tick(1);
    bus.rvalid = 1; bus.rdata = 32'h600DCAFE;
    tick(1);
    bus.rvalid = 0; bus.arready = 0;
    chk("t6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t6_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("t6_rsp_rdata", bus.rsp_rdata, 32'h600DCAFE);
    tick(3);

    for (int i = 0; i < 200 && !done2; i++) tick(1);
    chk("fp_done", {31'd0, done2}, 32'd1);
    chk("fp_count", fp_ids.size(), 32'd4);
    foreach (fp_ids[i]) chk("fp_grant", {31'd0, fp_ids[i]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
